// File: rtl/alu_arb_if.sv
// Per-port request/response channel between an ALU requester and alu_arbiter.
interface alu_arb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] req_in1;
  logic [DATA_W-1:0] req_in2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_in1, req_in2, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_in1, req_in2, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: IDLE -> EXEC -> RESP per operation.
// Define ALU_ARB_ROUND_ROBIN_EN for alternating arbitration; default is fixed priority to port 0.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_arb_if.slave          p0_if,
  alu_arb_if.slave          p1_if,
  output logic [OP_W-1:0]   alu_op_o,
  output logic [DATA_W-1:0] alu_in1_o,
  output logic [DATA_W-1:0] alu_in2_o,
  input  logic [DATA_W-1:0] alu_out_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] in1_q, in1_d;
  logic [DATA_W-1:0] in2_q, in2_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              winner_c;
  logic              ready0_c, ready1_c;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic              last_q, last_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      op_q       <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      rsp_data_q <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      op_q       <= op_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      rsp_data_q <= rsp_data_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  // Winner: 1 selects port 1; a lone requester always wins.
  always_comb begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
    if (p0_if.req_valid && p1_if.req_valid) winner_c = ~last_q;
    else                                    winner_c = ~p0_if.req_valid;
`else
    winner_c = ~p0_if.req_valid;
`endif
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    op_d       = op_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    rsp_data_d = rsp_data_q;
    ready0_c   = 1'b0;
    ready1_c   = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (p0_if.req_valid || p1_if.req_valid) begin
          ready0_c = ~winner_c;
          ready1_c = winner_c;
          op_d     = winner_c ? p1_if.req_op  : p0_if.req_op;
          in1_d    = winner_c ? p1_if.req_in1 : p0_if.req_in1;
          in2_d    = winner_c ? p1_if.req_in2 : p0_if.req_in2;
          grant_d  = winner_c;
`ifdef ALU_ARB_ROUND_ROBIN_EN
          last_d   = winner_c;
`endif
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = alu_out_i;
        state_d    = RESP;
      end
      RESP: begin
        if (grant_q ? p1_if.rsp_ready : p0_if.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign p0_if.req_ready = ready0_c;
  assign p1_if.req_ready = ready1_c;
  assign p0_if.rsp_valid = (state_q == RESP) && !grant_q;
  assign p1_if.rsp_valid = (state_q == RESP) &&  grant_q;
  assign p0_if.rsp_data  = rsp_data_q;
  assign p1_if.rsp_data  = rsp_data_q;
  assign alu_op_o        = op_q;
  assign alu_in1_o       = in1_q;
  assign alu_in2_o       = in2_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, scoreboard per port, corner sequences.
module tb_alu_arbiter;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  alu_op;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic        busy;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb0[$];
  logic [31:0] sb1[$];

  alu_arb_if p0 ();
  alu_arb_if p1 ();

  alu_arbiter dut (
    .clk(clk), .rst(rst), .p0_if(p0), .p1_if(p1),
    .alu_op_o(alu_op), .alu_in1_o(alu_in1), .alu_in2_o(alu_in2),
    .alu_out_i(alu_out), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the combinational alu; undefined opcodes give 0.
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_out = alu_in1 + alu_in2;
      OP_SUB:  alu_out = alu_in1 - alu_in2;
      OP_AND:  alu_out = alu_in1 & alu_in2;
      OP_OR:   alu_out = alu_in1 | alu_in2;
      OP_XOR:  alu_out = alu_in1 ^ alu_in2;
      OP_SLT:  alu_out = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
      OP_SLTU: alu_out = (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
      OP_SLL:  alu_out = alu_in1 << alu_in2[4:0];
      OP_SRL:  alu_out = alu_in1 >> alu_in2[4:0];
      OP_SRA:  alu_out = 32'($signed(alu_in1) >>> alu_in2[4:0]);
      default: alu_out = 32'd0;
    endcase
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Scoreboard: pop and compare on every completed response handshake.
  always @(negedge clk) begin
    if (p0.rsp_valid && p0.rsp_ready) begin
      if (sb0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
      else chk("rsp0_data", p0.rsp_data, sb0.pop_front());
    end
    if (p1.rsp_valid && p1.rsp_ready) begin
      if (sb1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
      else chk("rsp1_data", p1.rsp_data, sb1.pop_front());
    end
  end

  function automatic logic rsp_v(input int p);
    return (p == 0) ? p0.rsp_valid : p1.rsp_valid;
  endfunction

  task automatic set_req(input int p, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin p0.req_valid = v; p0.req_op = op; p0.req_in1 = a; p0.req_in2 = b; end
    else        begin p1.req_valid = v; p1.req_op = op; p1.req_in1 = a; p1.req_in2 = b; end
  endtask

  task automatic wait_acc(input int p, output int k);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((p == 0) ? (p0.req_valid && p0.req_ready) : (p1.req_valid && p1.req_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    k = cyc;
    chk($sformatf("accept%0d", p), 32'(ok), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb0.size() == 0 && sb1.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 32'(sb0.size() + sb1.size()), 32'd0);
    sb0.delete();
    sb1.delete();
  endtask

  // Single op with both rsp_ready high: checks busy and response timing around handshake cycle k.
  task automatic run_op(input int p, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int k;
    @(posedge clk); #1;
    set_req(p, 1'b1, op, a, b);
    if (p == 0) sb0.push_back(exp); else sb1.push_back(exp);
    wait_acc(p, k);
    @(posedge clk); #1;
    set_req(p, 1'b0, op, a, b);
    @(negedge clk);
    chk("busy_t1", 32'(busy), 32'd1);
    chk("rsp_early", 32'(rsp_v(p)), 32'd0);
    @(negedge clk);
    chk("lat_cycle", 32'(cyc - k), 32'd2);
    chk("rsp_t2", 32'(rsp_v(p)), 32'd1);
    chk("rsp_other", 32'(rsp_v(1 - p)), 32'd0);
    chk("busy_t2", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_t3", 32'(busy), 32'd0);
    drain();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int          port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[10];
  int   gseq[4];
  int   exp_seq[4];

  initial begin
    int k, g;
    bit h0, h1;
    vt[0] = '{0, OP_ADD,  32'd5,          32'd7,      32'd12};
    vt[1] = '{1, OP_SRA,  32'h8000_0000,  32'd4,      32'hF800_0000};
    vt[2] = '{0, 4'hF,    32'd3,          32'd4,      32'd0};
    vt[3] = '{1, OP_SUB,  32'd10,         32'd3,      32'd7};
    vt[4] = '{0, OP_SLT,  32'hFFFF_FFFF,  32'd1,      32'd1};
    vt[5] = '{1, OP_SLTU, 32'hFFFF_FFFF,  32'd1,      32'd0};
    vt[6] = '{0, OP_SLL,  32'd1,          32'd31,     32'h8000_0000};
    vt[7] = '{1, OP_SRL,  32'h8000_0000,  32'd4,      32'h0800_0000};
    vt[8] = '{0, OP_AND,  32'h0000_F0F0,  32'h0000_FF00, 32'h0000_F000};
    vt[9] = '{1, OP_ADD,  32'hFFFF_FFFF,  32'd1,      32'd0};

    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    p0.rsp_ready = 1'b1;
    p1.rsp_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp0v", 32'(p0.rsp_valid), 32'd0);
    chk("rst_rsp1v", 32'(p1.rsp_valid), 32'd0);
    chk("rst_rdy0", 32'(p0.req_ready), 32'd0);
    chk("rst_rdy1", 32'(p1.req_ready), 32'd0);
    chk("rst_op", 32'(alu_op), 32'd0);
    chk("rst_in1", alu_in1, 32'd0);
    chk("rst_in2", alu_in2, 32'd0);
    chk("rst_data", p0.rsp_data, 32'd0);
    rst = 1'b0;

    // Single-port vectors
    for (int i = 0; i < 10; i++) run_op(vt[i].port, vt[i].op, vt[i].a, vt[i].b, vt[i].exp);

    // Both ports requesting continuously
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1'b1, OP_SUB, 32'd10, 32'd3);
    set_req(1, 1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    g = 0;
    for (int c = 0; c < 60 && (p0.req_valid || p1.req_valid); c++) begin
      @(negedge clk);
      h0 = p0.req_valid && p0.req_ready;
      h1 = p1.req_valid && p1.req_ready;
      if (h0) begin sb0.push_back(32'd7); if (g < 4) gseq[g] = 0; g++; end
      if (h1) begin sb1.push_back(32'd1); if (g < 4) gseq[g] = 1; g++; end
      @(posedge clk); #1;
      if (h0 && g >= 4) p0.req_valid = 1'b0;
      if (h1 && g >= 4) p1.req_valid = 1'b0;
    end
    chk("both_done", 32'(p0.req_valid || p1.req_valid), 32'd0);
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("grant%0d", i), 32'(gseq[i]), 32'(exp_seq[i]));
    drain();

    // Response backpressure while port 1 waits
    @(posedge clk); #1;
    p0.rsp_ready = 1'b0;
    set_req(0, 1'b1, OP_XOR, 32'hFF, 32'h0F);
    sb0.push_back(32'hF0);
    wait_acc(0, k);
    @(posedge clk); #1;
    set_req(0, 1'b0, OP_XOR, 32'hFF, 32'h0F);
    set_req(1, 1'b1, OP_ADD, 32'd1, 32'd1);
    sb1.push_back(32'd2);
    for (int i = 0; i < 10 && !p0.rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(p0.rsp_valid), 32'd1);
      chk("hold_data", p0.rsp_data, 32'hF0);
      chk("hold_rdy1", 32'(p1.req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    p0.rsp_ready = 1'b1;
    wait_acc(1, k);
    @(posedge clk); #1;
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    drain();

    // Asynchronous reset during EXEC
    @(posedge clk); #1;
    set_req(0, 1'b1, OP_OR, 32'd1, 32'd2);
    sb0.push_back(32'd3);
    wait_acc(0, k);
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_op", 32'(alu_op), 32'd0);
    chk("arst_in1", alu_in1, 32'd0);
    chk("arst_in2", alu_in2, 32'd0);
    chk("arst_rsp0v", 32'(p0.rsp_valid), 32'd0);
    sb0.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_norsp", 32'(p0.rsp_valid), 32'd0);
    end
    run_op(0, OP_ADD, 32'd2, 32'd2, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
